// File: rtl/noc_pkg.sv
//==============================================================================
// Module      : noc_pkg
// Description : Shared NoC types for the output-channel stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package noc_pkg;

   typedef enum logic [1:0] {
      FT_HEAD     = 2'd0,
      FT_BODY     = 2'd1,
      FT_TAIL     = 2'd2,
      FT_HEADTAIL = 2'd3
   } flit_type_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } outc_vc_state_e;

   // Reference link layout for the default configuration (4 VCs, 64-bit flits).
   localparam int c_LINK_VCH_W  = 2;
   localparam int c_LINK_DATA_W = 64;

   typedef struct packed {
      logic                     vld;
      logic [c_LINK_VCH_W-1:0]  vch;
      logic [c_LINK_DATA_W-1:0] data;
   } outc_link_t;

   function automatic int cr_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/outputc_vc_ctrl.sv
//==============================================================================
// Module      : outputc_vc_ctrl
// Description : One VC's ownership FSM, credit counter and error pulses.
//               Optional OUTPUTC_STATS_EN adds flit/packet counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module outputc_vc_ctrl
   import noc_pkg::*;
#(
   parameter int BUF_DEPTH = 8,
   parameter int PKTLEN    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_send,
   input  flit_type_e i_type,
   input  logic       i_cr_ret,
   input  logic       i_dn_lck,
   output logic       o_rdy,
   output logic       o_lck,
   output logic       o_cr_avail,
   output logic       o_err_uf,
   output logic       o_err_of
`ifdef OUTPUTC_STATS_EN
   , output logic       o_err_proto
   , output logic [31:0] o_stat_flits
   , output logic [31:0] o_stat_pkts
`endif
);

   localparam int CW = cr_width(BUF_DEPTH);
   localparam logic [CW-1:0] c_FULL = CW'(BUF_DEPTH);
   localparam logic [CW-1:0] c_PKT  = CW'(PKTLEN);

   outc_vc_state_e r_state, w_state_nxt;
   logic [CW-1:0]  r_credit, w_credit_nxt;
   logic           w_proto, w_pkt_end;

   always_comb begin
      w_state_nxt = r_state;
      w_proto     = 1'b0;
      w_pkt_end   = 1'b0;
      case (r_state)
         IDLE: if (i_send) begin
            if (i_type == FT_HEAD) begin
               w_state_nxt = ACTIVE;
            end else if (i_type == FT_HEADTAIL) begin
               w_state_nxt = DRAIN;
               w_pkt_end   = 1'b1;
            end else begin
               w_proto = 1'b1;
            end
         end
         ACTIVE: if (i_send) begin
            if (i_type == FT_TAIL) begin
               w_state_nxt = DRAIN;
               w_pkt_end   = 1'b1;
            end else if (i_type != FT_BODY) begin
               w_proto = 1'b1;
            end
         end
         // Release waits on the downstream lock; any flit here is out of protocol.
         DRAIN: begin
            w_proto = i_send;
            if (!i_dn_lck) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_credit_nxt = r_credit;
      o_err_uf     = 1'b0;
      o_err_of     = 1'b0;
      if (i_send && !i_cr_ret) begin
         if (r_credit == '0) o_err_uf = 1'b1;
         else                w_credit_nxt = r_credit - 1'b1;
      end else if (i_cr_ret && !i_send) begin
         if (r_credit == c_FULL) o_err_of = 1'b1;
         else                    w_credit_nxt = r_credit + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_credit <= c_FULL;
      end else begin
         r_state  <= w_state_nxt;
         r_credit <= w_credit_nxt;
      end
   end

   assign o_rdy      = (r_state == IDLE) && (r_credit >= c_PKT);
   assign o_lck      = (r_state != IDLE);
   assign o_cr_avail = (r_credit != '0);

`ifdef OUTPUTC_STATS_EN
   logic [31:0] r_flits, r_pkts;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flits <= '0;
         r_pkts  <= '0;
      end else begin
         if (i_send)    r_flits <= r_flits + 32'd1;
         if (w_pkt_end) r_pkts  <= r_pkts + 32'd1;
      end
   end

   assign o_err_proto  = w_proto;
   assign o_stat_flits = r_flits;
   assign o_stat_pkts  = r_pkts;
`else
   logic [1:0] w_unused;
   assign w_unused = {w_proto, w_pkt_end};
`endif

endmodule

`default_nettype wire

// File: rtl/outputc_vc.sv
//==============================================================================
// Module      : outputc_vc
// Description : Output-channel stage: link register, per-VC credits/locking,
//               sticky error flags. OUTPUTC_STATS_EN enables per-VC stats.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module outputc_vc
   import noc_pkg::*;
#(
   parameter int ROUTERID  = 0,
   parameter int PCHID     = 0,
   parameter int VCH_N     = 4,
   parameter int FLIT_W    = 64,
   parameter int BUF_DEPTH = 8,
   parameter int PKTLEN    = 4,
   localparam int VW       = (VCH_N > 1) ? $clog2(VCH_N) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flit_vld_i,
   input  logic [VW-1:0]     flit_vch_i,
   input  logic [1:0]        flit_type_i,
   input  logic [FLIT_W-1:0] flit_data_i,
   output logic              link_vld_o,
   output logic [VW-1:0]     link_vch_o,
   output logic [FLIT_W-1:0] link_data_o,
   input  logic              cr_vld_i,
   input  logic [VW-1:0]     cr_vch_i,
   input  logic [VCH_N-1:0]  dn_lck_i,
   output logic [VCH_N-1:0]  rdy_o,
   output logic [VCH_N-1:0]  lck_o,
   output logic [VCH_N-1:0]  cr_avail_o,
   output logic [1:0]        err_o
`ifdef OUTPUTC_STATS_EN
   , output logic [VCH_N-1:0][31:0] stat_flits_o
   , output logic [VCH_N-1:0][31:0] stat_pkts_o
`endif
);

   // Router/channel indices only tag debug views.
   localparam int c_unused_id = ROUTERID ^ PCHID;

   logic              r_link_vld;
   logic [VW-1:0]     r_link_vch;
   logic [FLIT_W-1:0] r_link_data;
   logic [1:0]        r_err;
   logic [VCH_N-1:0]  w_err_uf, w_err_of;
   logic              w_err_lo;

`ifdef OUTPUTC_STATS_EN
   logic [VCH_N-1:0]  w_err_proto;
`endif

   generate
      for (genvar v = 0; v < VCH_N; v++) begin : g_vc
         outputc_vc_ctrl #(
            .BUF_DEPTH (BUF_DEPTH),
            .PKTLEN    (PKTLEN)
         ) u_ctrl (
            .clk        (clk),
            .rst        (rst),
            .i_send     (flit_vld_i && (flit_vch_i == VW'(v))),
            .i_type     (flit_type_e'(flit_type_i)),
            .i_cr_ret   (cr_vld_i && (cr_vch_i == VW'(v))),
            .i_dn_lck   (dn_lck_i[v]),
            .o_rdy      (rdy_o[v]),
            .o_lck      (lck_o[v]),
            .o_cr_avail (cr_avail_o[v]),
            .o_err_uf   (w_err_uf[v]),
            .o_err_of   (w_err_of[v])
`ifdef OUTPUTC_STATS_EN
            , .o_err_proto  (w_err_proto[v])
            , .o_stat_flits (stat_flits_o[v])
            , .o_stat_pkts  (stat_pkts_o[v])
`endif
         );
      end
   endgenerate

`ifdef OUTPUTC_STATS_EN
   assign w_err_lo = (|w_err_uf) | (|w_err_proto);
`else
   assign w_err_lo = |w_err_uf;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_link_vld  <= 1'b0;
         r_link_vch  <= '0;
         r_link_data <= '0;
         r_err       <= 2'b00;
      end else begin
         r_link_vld  <= flit_vld_i;
         r_link_vch  <= flit_vch_i;
         r_link_data <= flit_data_i;
         r_err[0]    <= r_err[0] | w_err_lo;
         r_err[1]    <= r_err[1] | (|w_err_of);
      end
   end

   assign link_vld_o  = r_link_vld;
   assign link_vch_o  = r_link_vch;
   assign link_data_o = r_link_data;
   assign err_o       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_outputc_vc.sv
//==============================================================================
// Module      : tb_outputc_vc
// Description : Self-checking bench for outputc_vc (directed table + random).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_outputc_vc;
   import noc_pkg::*;

   localparam int VCH_N = 4, FLIT_W = 64, BUF_DEPTH = 8, PKTLEN = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              flit_vld_i, cr_vld_i;
   logic [1:0]        flit_vch_i, flit_type_i, cr_vch_i, link_vch_o, err_o;
   logic [63:0]       flit_data_i, link_data_o;
   logic              link_vld_o;
   logic [3:0]        dn_lck_i, rdy_o, lck_o, cr_avail_o;
`ifdef OUTPUTC_STATS_EN
   logic [3:0][31:0]  stat_flits_o, stat_pkts_o;
`endif

   int n_tests = 0, n_fail = 0;

   outputc_vc #(.ROUTERID(0), .PCHID(0), .VCH_N(VCH_N), .FLIT_W(FLIT_W),
                .BUF_DEPTH(BUF_DEPTH), .PKTLEN(PKTLEN)) dut (
      .clk(clk), .rst(rst), .flit_vld_i(flit_vld_i), .flit_vch_i(flit_vch_i),
      .flit_type_i(flit_type_i), .flit_data_i(flit_data_i),
      .link_vld_o(link_vld_o), .link_vch_o(link_vch_o), .link_data_o(link_data_o),
      .cr_vld_i(cr_vld_i), .cr_vch_i(cr_vch_i), .dn_lck_i(dn_lck_i),
      .rdy_o(rdy_o), .lck_o(lck_o), .cr_avail_o(cr_avail_o), .err_o(err_o)
`ifdef OUTPUTC_STATS_EN
      , .stat_flits_o(stat_flits_o), .stat_pkts_o(stat_pkts_o)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: credits, packet phase (0 free, 1 in packet, 2 awaiting downstream)
   int          m_cr[VCH_N];
   int          m_ph[VCH_N];
   logic [1:0]  m_err;
   logic        m_lvld;
   logic [1:0]  m_lvch;
   logic [63:0] m_ldata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int v = 0; v < VCH_N; v++) begin
         m_cr[v] = BUF_DEPTH;
         m_ph[v] = 0;
      end
      m_err = 2'b00; m_lvld = 1'b0; m_lvch = 2'd0; m_ldata = 64'd0;
   endtask

   task automatic model_step();
      for (int v = 0; v < VCH_N; v++) begin
         bit s, r, viol;
         s = flit_vld_i && (flit_vch_i == 2'(v));
         r = cr_vld_i && (cr_vch_i == 2'(v));
         viol = 1'b0;
         if (s && !r) begin
            if (m_cr[v] == 0) m_err[0] = 1'b1; else m_cr[v]--;
         end else if (r && !s) begin
            if (m_cr[v] == BUF_DEPTH) m_err[1] = 1'b1; else m_cr[v]++;
         end
         if (m_ph[v] == 2) begin
            viol = s;
            if (!dn_lck_i[v]) m_ph[v] = 0;
         end else if (s) begin
            if (m_ph[v] == 0) begin
               if (flit_type_i == FT_HEAD) m_ph[v] = 1;
               else if (flit_type_i == FT_HEADTAIL) m_ph[v] = 2;
               else viol = 1'b1;
            end else begin
               if (flit_type_i == FT_TAIL) m_ph[v] = 2;
               else if (flit_type_i != FT_BODY) viol = 1'b1;
            end
         end
`ifdef OUTPUTC_STATS_EN
         if (viol) m_err[0] = 1'b1;
`endif
         if (viol) begin end
      end
      m_lvld = flit_vld_i; m_lvch = flit_vch_i; m_ldata = flit_data_i;
   endtask

   task automatic model_check();
      logic [3:0] e_rdy, e_lck, e_cav;
      for (int v = 0; v < VCH_N; v++) begin
         e_rdy[v] = (m_ph[v] == 0) && (m_cr[v] >= PKTLEN);
         e_lck[v] = (m_ph[v] != 0);
         e_cav[v] = (m_cr[v] != 0);
      end
      chk("rdy", 64'(rdy_o), 64'(e_rdy));
      chk("lck", 64'(lck_o), 64'(e_lck));
      chk("cr_avail", 64'(cr_avail_o), 64'(e_cav));
      chk("err", 64'(err_o), 64'(m_err));
      chk("link_vld", 64'(link_vld_o), 64'(m_lvld));
      if (m_lvld) begin
         chk("link_vch", 64'(link_vch_o), 64'(m_lvch));
         chk("link_data", link_data_o, m_ldata);
      end
   endtask

   task automatic drive(input logic vld, input logic [1:0] vch, input logic [1:0] ft,
                        input logic [63:0] data, input logic crv, input logic [1:0] crc,
                        input logic [3:0] dn);
      flit_vld_i = vld; flit_vch_i = vch; flit_type_i = ft; flit_data_i = data;
      cr_vld_i = crv; cr_vch_i = crc; dn_lck_i = dn;
   endtask

   task automatic step();
      @(posedge clk); #1;
      model_step();
      model_check();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rdy"}, 64'(rdy_o), 64'hF);
      chk({tag, "_lck"}, 64'(lck_o), 64'h0);
      chk({tag, "_cav"}, 64'(cr_avail_o), 64'hF);
      chk({tag, "_err"}, 64'(err_o), 64'h0);
      chk({tag, "_lvld"}, 64'(link_vld_o), 64'h0);
      chk({tag, "_lvch"}, 64'(link_vch_o), 64'h0);
      chk({tag, "_ldata"}, link_data_o, 64'h0);
   endtask

   typedef struct {
      logic vld; logic [1:0] vch; logic [1:0] ft; logic [63:0] data;
      logic crv; logic [1:0] crc; logic [3:0] dn;
      logic [3:0] e_rdy, e_lck, e_cav; logic [1:0] e_err; logic e_lvld;
   } vec_t;

   vec_t tbl[15];

   initial begin
      //          vld vch ft  data      crv crc dn    rdy   lck   cav   err    lvld
      tbl[0]  = '{0, 0, 0, 64'h0,  0, 0, 4'h0, 4'hF, 4'h0, 4'hF, 2'b00, 0};
      tbl[1]  = '{1, 1, 0, 64'hA1, 0, 0, 4'h0, 4'hD, 4'h2, 4'hF, 2'b00, 1};
      tbl[2]  = '{1, 1, 1, 64'hA2, 0, 0, 4'h0, 4'hD, 4'h2, 4'hF, 2'b00, 1};
      tbl[3]  = '{1, 1, 1, 64'hA3, 0, 0, 4'h0, 4'hD, 4'h2, 4'hF, 2'b00, 1};
      tbl[4]  = '{1, 1, 2, 64'hA4, 0, 0, 4'h2, 4'hD, 4'h2, 4'hF, 2'b00, 1};
      tbl[5]  = '{0, 0, 0, 64'h0,  0, 0, 4'h2, 4'hD, 4'h2, 4'hF, 2'b00, 0};
      tbl[6]  = '{0, 0, 0, 64'h0,  0, 0, 4'h2, 4'hD, 4'h2, 4'hF, 2'b00, 0};
      tbl[7]  = '{0, 0, 0, 64'h0,  0, 0, 4'h2, 4'hD, 4'h2, 4'hF, 2'b00, 0};
      tbl[8]  = '{0, 0, 0, 64'h0,  0, 0, 4'h0, 4'hF, 4'h0, 4'hF, 2'b00, 0};
      tbl[9]  = '{1, 2, 3, 64'hB0, 1, 2, 4'h0, 4'hB, 4'h4, 4'hF, 2'b00, 1};
      tbl[10] = '{0, 0, 0, 64'h0,  1, 1, 4'h0, 4'hF, 4'h0, 4'hF, 2'b00, 0};
      tbl[11] = '{0, 0, 0, 64'h0,  1, 1, 4'h0, 4'hF, 4'h0, 4'hF, 2'b00, 0};
      tbl[12] = '{0, 0, 0, 64'h0,  1, 1, 4'h0, 4'hF, 4'h0, 4'hF, 2'b00, 0};
      tbl[13] = '{0, 0, 0, 64'h0,  1, 1, 4'h0, 4'hF, 4'h0, 4'hF, 2'b00, 0};
      tbl[14] = '{0, 0, 0, 64'h0,  1, 1, 4'h0, 4'hF, 4'h0, 4'hF, 2'b10, 0};

      rst = 1'b1;
      drive(0, 0, 0, 64'h0, 0, 0, 4'h0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rst = 1'b0;

      // Directed table: VC1 packet, downstream hold, simultaneous send/return, overflow
      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].vld, tbl[i].vch, tbl[i].ft, tbl[i].data, tbl[i].crv, tbl[i].crc, tbl[i].dn);
         step();
         chk($sformatf("tbl%0d_rdy", i), 64'(rdy_o), 64'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d_lck", i), 64'(lck_o), 64'(tbl[i].e_lck));
         chk($sformatf("tbl%0d_cav", i), 64'(cr_avail_o), 64'(tbl[i].e_cav));
         chk($sformatf("tbl%0d_err", i), 64'(err_o), 64'(tbl[i].e_err));
         chk($sformatf("tbl%0d_lvld", i), 64'(link_vld_o), 64'(tbl[i].e_lvld));
         if (tbl[i].e_lvld) begin
            chk($sformatf("tbl%0d_lvch", i), 64'(link_vch_o), 64'(tbl[i].vch));
            chk($sformatf("tbl%0d_ldata", i), link_data_o, tbl[i].data);
         end
      end

      // Exhaust VC3 credits with an 8-flit packet, then underflow
      drive(1, 3, FT_HEAD, 64'hC0, 0, 0, 4'h8);
      step();
      for (int i = 0; i < 6; i++) begin
         drive(1, 3, FT_BODY, 64'hC1 + 64'(i), 0, 0, 4'h8);
         step();
      end
      drive(1, 3, FT_TAIL, 64'hC7, 0, 0, 4'h8);
      step();
      chk("vc3_cav_zero", 64'(cr_avail_o[3]), 64'h0);
      drive(1, 3, FT_BODY, 64'hC8, 0, 0, 4'h8);
      step();
      chk("underflow_err", 64'(err_o), 64'h3);
      chk("vc3_cav_stays0", 64'(cr_avail_o[3]), 64'h0);
      drive(0, 0, 0, 64'h0, 0, 0, 4'h0);
      step();
      chk("vc3_idle_no_rdy", 64'({lck_o[3], rdy_o[3]}), 64'h0);
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 0, 64'h0, 1, 3, 4'h0);
         step();
      end
      chk("err_sticky", 64'(err_o), 64'h3);

      // Asynchronous reset in the middle of a VC0 packet
      drive(1, 0, FT_HEAD, 64'hD0, 0, 0, 4'h0);
      step();
      drive(1, 0, FT_BODY, 64'hD1, 0, 0, 4'h0);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_vals("midrst");
      model_reset();
      drive(0, 0, 0, 64'h0, 0, 0, 4'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1, 0, FT_HEAD, 64'hD2, 0, 0, 4'h0);
      step();
      chk("fresh_head_lck", 64'(lck_o), 64'h1);

      // Randomised traffic against the model
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               {$urandom, $urandom}, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               4'($urandom));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
